// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: merges core writebacks with buffered
// accelerator results onto one RF write port, with a starvation guard.
module wb_arbiter #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_W     = 5,
    parameter int ACC_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_wb_valid,
    input  logic [1:0]            core_wb_sel,
    input  logic [XLEN-1:0]       alu_result,
    input  logic [XLEN-1:0]       load_data,
    input  logic [XLEN-1:0]       pc_plus4,
    input  logic [REG_ADDR_W-1:0] core_rd,
    output logic                  core_stall,
    input  logic                  acc_valid,
    output logic                  acc_ready,
    input  logic [REG_ADDR_W-1:0] acc_rd,
    input  logic [XLEN-1:0]       acc_data,
    output logic                  acc_pending,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata
);

    localparam int PTR_W = $clog2(ACC_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ACC_FIFO_DEPTH);
    localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GRANT_IDLE,
        GRANT_CORE,
        GRANT_ACC,
        GRANT_FORCE
    } grant_t;

    grant_t                grant;
    logic [XLEN-1:0]       mem_data [ACC_FIFO_DEPTH];
    logic [REG_ADDR_W-1:0] mem_rd   [ACC_FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [ST_W-1:0]       starve_cnt;
    logic                  not_empty;
    logic                  push;
    logic                  pop;
    logic [XLEN-1:0]       core_data;

    assign not_empty   = (count != '0);
    assign acc_ready   = (count != FULL_CNT);
    assign acc_pending = not_empty;
    // Results addressed to x0 finish the handshake but are dropped here.
    assign push        = acc_valid && acc_ready && (acc_rd != '0);
    assign pop         = (grant == GRANT_ACC) || (grant == GRANT_FORCE);
    assign core_stall  = (grant == GRANT_FORCE);

    always_comb begin
        core_data = '0;
        case (core_wb_sel)
            2'd0:    core_data = alu_result;
            2'd1:    core_data = load_data;
            2'd2:    core_data = pc_plus4;
            default: core_data = '0;
        endcase
    end

    always_comb begin
        grant = GRANT_IDLE;
        if (not_empty && starve_cnt == ST_MAX) begin
            grant = GRANT_FORCE;
        end else if (core_wb_valid) begin
            grant = GRANT_CORE;
        end else if (not_empty) begin
            grant = GRANT_ACC;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= acc_data;
            mem_rd[wr_ptr]   <= acc_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (pop || !not_empty) begin
                starve_cnt <= '0;
            end else if (grant == GRANT_CORE && starve_cnt != ST_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            case (grant)
                GRANT_CORE: begin
                    rf_we    <= (core_rd != '0);
                    rf_waddr <= core_rd;
                    rf_wdata <= core_data;
                end
                GRANT_ACC, GRANT_FORCE: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= mem_rd[rd_ptr];
                    rf_wdata <= mem_data[rd_ptr];
                end
                default: rf_we <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_wb_valid;
    logic [1:0]  core_wb_sel;
    logic [31:0] alu_result;
    logic [31:0] load_data;
    logic [31:0] pc_plus4;
    logic [4:0]  core_rd;
    logic        core_stall;
    logic        acc_valid;
    logic        acc_ready;
    logic [4:0]  acc_rd;
    logic [31:0] acc_data;
    logic        acc_pending;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int err_cnt = 0;
    int chk_cnt = 0;

    wb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .core_wb_valid(core_wb_valid),
        .core_wb_sel  (core_wb_sel),
        .alu_result   (alu_result),
        .load_data    (load_data),
        .pc_plus4     (pc_plus4),
        .core_rd      (core_rd),
        .core_stall   (core_stall),
        .acc_valid    (acc_valid),
        .acc_ready    (acc_ready),
        .acc_rd       (acc_rd),
        .acc_data     (acc_data),
        .acc_pending  (acc_pending),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic [4:0] addr, input logic [31:0] data);
        check({tag, "_we"}, 32'(rf_we), 32'd1);
        check({tag, "_addr"}, 32'(rf_waddr), 32'(addr));
        check({tag, "_data"}, rf_wdata, data);
    endtask

    logic [31:0] sel_exp [4];

    initial begin
        rst_n = 1'b0; core_wb_valid = 1'b0; core_wb_sel = 2'd0;
        alu_result = 32'h0; load_data = 32'h0; pc_plus4 = 32'h0; core_rd = 5'd0;
        acc_valid = 1'b0; acc_rd = 5'd0; acc_data = 32'h0;
        step(); step();
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_waddr", 32'(rf_waddr), 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_pending", 32'(acc_pending), 32'd0);
        check("rst_ready", 32'(acc_ready), 32'd1);
        check("rst_stall", 32'(core_stall), 32'd0);
        rst_n = 1'b1;

        // Core only: each select source in turn
        sel_exp[0] = 32'h02333333; sel_exp[1] = 32'h00002034;
        sel_exp[2] = 32'h01234567; sel_exp[3] = 32'h00000000;
        alu_result = 32'h02333333; load_data = 32'h00002034; pc_plus4 = 32'h01234567;
        core_rd = 5'd5; core_wb_valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            core_wb_sel = 2'(s);
            step();
            check_wr($sformatf("core_sel%0d", s), 5'd5, sel_exp[s]);
        end
        core_rd = 5'd0; core_wb_sel = 2'd0;
        step();
        check("core_x0_we", 32'(rf_we), 32'd0);
        core_wb_valid = 1'b0;
        step();
        check("idle_we", 32'(rf_we), 32'd0);

        // Accelerator idle drain: push at N, write visible at N+2
        acc_valid = 1'b1; acc_rd = 5'd7; acc_data = 32'hDEADBEEF;
        step();
        acc_valid = 1'b0;
        check("drain_pend", 32'(acc_pending), 32'd1);
        check("drain_early_we", 32'(rf_we), 32'd0);
        step();
        check_wr("drain", 5'd7, 32'hDEADBEEF);
        check("drain_pend_clr", 32'(acc_pending), 32'd0);
        step();
        check("drain_after_we", 32'(rf_we), 32'd0);

        // FIFO full with the core busy, then drain in push order
        core_wb_valid = 1'b1; core_wb_sel = 2'd0; core_rd = 5'd3; alu_result = 32'h100;
        for (int i = 0; i < 4; i++) begin
            acc_valid = 1'b1; acc_rd = 5'(10 + i); acc_data = 32'hA0 + 32'(i);
            #1;
            check($sformatf("full_ready%0d", i), 32'(acc_ready), 32'd1);
            step();
            check_wr($sformatf("full_core%0d", i), 5'd3, 32'h100);
        end
        core_wb_valid = 1'b0;
        acc_rd = 5'd14; acc_data = 32'hA4;
        #1;
        check("full_ready_lo", 32'(acc_ready), 32'd0);
        step();
        check_wr("full_pop0", 5'd10, 32'hA0);
        check("full_ready_reopen", 32'(acc_ready), 32'd1);
        step();
        acc_valid = 1'b0;
        check_wr("full_pop1", 5'd11, 32'hA1);
        step(); check_wr("full_pop2", 5'd12, 32'hA2);
        step(); check_wr("full_pop3", 5'd13, 32'hA3);
        step(); check_wr("full_pop4", 5'd14, 32'hA4);
        check("full_pend_clr", 32'(acc_pending), 32'd0);
        step();
        check("full_idle_we", 32'(rf_we), 32'd0);

        // Starvation guard: one queued entry, core valid every cycle
        core_wb_valid = 1'b1; core_rd = 5'd6; alu_result = 32'h0FFF;
        acc_valid = 1'b1; acc_rd = 5'd20; acc_data = 32'h55;
        step();
        acc_valid = 1'b0;
        check_wr("starve_push_core", 5'd6, 32'h0FFF);
        for (int i = 0; i < 8; i++) begin
            alu_result = 32'h1000 + 32'(i);
            #1;
            check($sformatf("starve_nostall%0d", i), 32'(core_stall), 32'd0);
            step();
            check_wr($sformatf("starve_core%0d", i), 5'd6, 32'h1000 + 32'(i));
        end
        alu_result = 32'h777;
        #1;
        check("starve_stall", 32'(core_stall), 32'd1);
        step();
        check_wr("starve_force", 5'd20, 32'h55);
        check("starve_stall_clr", 32'(core_stall), 32'd0);
        step();
        check_wr("starve_held", 5'd6, 32'h777);

        // Reset mid-operation with three entries queued
        for (int i = 0; i < 3; i++) begin
            acc_valid = 1'b1; acc_rd = 5'(21 + i); acc_data = 32'hB0 + 32'(i);
            step();
        end
        acc_valid = 1'b0;
        check("mid_pend", 32'(acc_pending), 32'd1);
        rst_n = 1'b0; core_wb_valid = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_we", 32'(rf_we), 32'd0);
        check("mid_rst_pend", 32'(acc_pending), 32'd0);
        check("mid_rst_ready", 32'(acc_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("mid_no_stale%0d", i), 32'(rf_we), 32'd0);
        end

        // Push addressed to x0: handshake only
        acc_valid = 1'b1; acc_rd = 5'd0; acc_data = 32'h99;
        #1;
        check("x0_ready", 32'(acc_ready), 32'd1);
        step();
        acc_valid = 1'b0;
        check("x0_pend", 32'(acc_pending), 32'd0);
        step();
        check("x0_we0", 32'(rf_we), 32'd0);
        step();
        check("x0_we1", 32'(rf_we), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Register-file writeback arbiter: the consumer side of the core's 4:1 writeback-source selection. It merges core writebacks (ALU result, load data, PC+4 or zero, chosen by a 2-bit select) with asynchronous GEMM-accelerator results into the single register-file write port. Accelerator results are buffered in a small FIFO and drained in idle core cycles, with a starvation guard that stalls the core when needed. It sits between the execute/memory stages plus the accelerator and the register file.

Parameters:
XLEN, 32, data width
REG_ADDR_W, 5, register index width
ACC_FIFO_DEPTH, 4, accelerator result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive core-won cycles with FIFO non-empty before a forced drain

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
core_wb_valid  input  1  core has a writeback this cycle
core_wb_sel  input  2  0=alu_result, 1=load_data, 2=pc_plus4, 3=zero
alu_result  input  XLEN  ALU result
load_data  input  XLEN  load data
pc_plus4  input  XLEN  link value
core_rd  input  REG_ADDR_W  core destination register
core_stall  output  1  core must hold its writeback this cycle (combinational)
acc_valid  input  1  accelerator result valid
acc_ready  output  1  FIFO can accept
acc_rd  input  REG_ADDR_W  accelerator destination register
acc_data  input  XLEN  accelerator result
acc_pending  output  1  FIFO non-empty (registered)
rf_we  output  1  register-file write enable (registered)
rf_waddr  output  REG_ADDR_W  write address (registered)
rf_wdata  output  XLEN  write data (registered)

Behaviour:
- Reset (rst_n=0 at a clk edge): rf_we=0, rf_waddr=0, rf_wdata=0, FIFO empty, acc_pending=0, starve_cnt=0. acc_ready=1 and core_stall=0 from the first cycle after reset. Reset mid-operation discards all FIFO contents and in-flight writes.
- Data select: 0→alu_result, 1→load_data, 2→pc_plus4, 3→32'h0.
- FIFO push: when acc_valid && acc_ready. acc_ready = !full, derived from registered state only; a pop in the same cycle does not open a slot. Results with acc_rd==0 complete the handshake but are not stored.
- Grant per cycle (combinational), with the selected write registered at the next edge (1-cycle latency):
  - FORCE: FIFO non-empty && starve_cnt==STARVE_LIMIT → pop the FIFO head to the RF, core_stall=1, and the core write is not taken (the core holds it).
  - CORE: otherwise, if core_wb_valid → write the core value.
  - ACC: otherwise, if FIFO non-empty → pop the head to the RF.
  - IDLE: rf_we=0 next cycle; rf_waddr and rf_wdata hold their values.
- x0 writes: a core write with core_rd==0 consumes its grant but produces rf_we=0.
- starve_cnt: increments when the FIFO is non-empty and CORE wins; clears on any pop or when the FIFO is empty; saturates at STARVE_LIMIT.
- Accelerator minimum latency: push at cycle N, earliest pop at N+1, rf_we at N+2. There is no bypass.
- Simultaneous push and pop: legal when the FIFO is not full, and the count is unchanged. Pointers wrap modulo ACC_FIFO_DEPTH.
- acc_pending reflects the registered count != 0.
- Ordering: accelerator results are written in arrival order. Core writes are never reordered among themselves.

Test Plan:
- Core only: reset, then sel=0..3 with alu_result=32'h02333333, load_data=32'h00002034, pc_plus4=32'h01234567, rd=5 → next cycle rf_wdata is each value in turn (last 0), rf_we=1, rf_waddr=5; rd=0 → rf_we=0.
- Accelerator idle drain: core_wb_valid=0, push acc_rd=7, acc_data=32'hDEADBEEF at cycle N → rf_we=1, rf_waddr=7, rf_wdata=32'hDEADBEEF at N+2; acc_pending returns to 0.
- FIFO full: core_wb_valid=1 continuously, push 4 results → acc_ready=0 after the 4th; a 5th acc_valid is held; after a pop, acc_ready=1 the following cycle; results are written in push order.
- Starvation: FIFO holds 1 entry, core_wb_valid=1 every cycle → after 8 core writes, core_stall=1 for one cycle, the FIFO head is written, then the held core write lands the next cycle.
- Reset mid-operation: FIFO holds 3 entries, rst_n=0 for one edge → rf_we=0, acc_pending=0, acc_ready=1, and no stale accelerator writes afterwards.
- acc_rd=0 push: the handshake completes, acc_pending stays 0, and no RF write occurs.
